// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
// APB completer backed by NUM_REGS 32-bit read/write registers. Each transfer
// is held off by a fixed WAIT_CYCLES pready-low access cycles. Misaligned or
// out-of-range addresses complete with pslverr=1. An error never writes.
//
// Handshake: a transfer starts on the edge that sees psel=1, penable=0
// (setup). The master then holds psel=1, penable=1 (access) until it sees
// pready=1. pready is high for exactly one cycle, and the edge that ends that
// cycle closes the transfer. Dropping psel or penable while pready is still
// low aborts the transfer: nothing is written and no response is given.
//
// Ports:
//   pclk        in   APB clock, rising edge
//   prst_n      in   asynchronous active-low reset
//   psel        in   select from master
//   penable     in   access-phase indicator
//   paddr[31:0] in   byte address
//   pwrite      in   1 = write, 0 = read
//   pwdata[31:0]in   write data
//   pready      out  transfer completion (registered)
//   prdata[31:0]out  read data, valid only while pready=1 (registered)
//   pslverr     out  error response, valid only while pready=1 (registered)
//   o_dbg_state out  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
// -----------------------------------------------------------------------------
module apb_slave_regfile #(
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        pclk,
  input  logic        prst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic [1:0]  o_dbg_state
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  logic [31:0] r_paddr;
  logic        r_pwrite;
  logic [31:0] r_pwdata;
  logic [31:0] r_regs [NUM_REGS];

  logic        w_setup;
  logic        w_access;
  logic        w_capture;
  logic        w_load_resp;
  logic        w_commit;

  logic [31:0]      w_dec_addr;
  logic             w_dec_write;
  logic             w_dec_err;
  logic [IDX_W-1:0] w_dec_idx;

  assign w_setup  = psel & ~penable;
  assign w_access = psel & penable;

  // With WAIT_CYCLES=0 the response is loaded on the same edge that captures
  // the transfer, so in IDLE the decoder must look at the live bus. In every
  // other state it sees only the latched copies.
  assign w_dec_addr  = (r_state == S_IDLE) ? paddr  : r_paddr;
  assign w_dec_write = (r_state == S_IDLE) ? pwrite : r_pwrite;
  assign w_dec_err   = (w_dec_addr[1:0] != 2'b00) ||
                       (w_dec_addr[31:IDX_W+2] != '0);
  assign w_dec_idx   = w_dec_addr[IDX_W+1:2];

  assign o_dbg_state = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_load_resp = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = S_RESP;
            w_load_resp = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (w_access) begin
          if (r_cnt == 4'd1) begin
            w_state_nxt = S_RESP;
            w_load_resp = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_commit    = w_access & r_pwrite & ~w_dec_err;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_paddr  <= 32'd0;
      r_pwrite <= 1'b0;
      r_pwdata <= 32'd0;
    end else if (w_capture) begin
      r_paddr  <= paddr;
      r_pwrite <= pwrite;
      r_pwdata <= pwdata;
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 32'd0;
    end else if (w_commit) begin
      r_regs[w_dec_idx] <= r_pwdata;
    end
  end

  // Response registers: loaded on the edge entering RESP, cleared on the
  // closing edge, so pready is high for exactly one cycle.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= 32'd0;
    end else begin
      pready  <= w_load_resp;
      pslverr <= w_load_resp & w_dec_err;
      prdata  <= (w_load_resp && !w_dec_err && !w_dec_write) ?
                 r_regs[w_dec_idx] : 32'd0;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regfile
// Three instances share one APB bus (separate psel each) with WAIT_CYCLES of
// 1, 0 and 15. The driver issues directed transfers and pushes the expected
// {instance, pslverr, prdata} into exp_q; the monitor pops on every pready.
// -----------------------------------------------------------------------------
module tb_apb_slave_regfile;

  localparam int NDUT = 3;
  localparam int WCYC [NDUT] = '{1, 0, 15};

  logic        pclk = 1'b0;
  logic        prst_n;
  logic [2:0]  psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [2:0]  pready;
  logic [2:0]  pslverr;
  logic [31:0] prdata [NDUT];
  logic [1:0]  dbg    [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  logic [34:0] exp_q[$];
  logic [2:0]  prev_rdy;

  // ---------------- clock / reset ----------------
  always #5 pclk = ~pclk;

  apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(1)) u_dut0 (
    .pclk(pclk), .prst_n(prst_n), .psel(psel[0]), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pready(pready[0]),
    .prdata(prdata[0]), .pslverr(pslverr[0]), .o_dbg_state(dbg[0]));

  apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(0)) u_dut1 (
    .pclk(pclk), .prst_n(prst_n), .psel(psel[1]), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pready(pready[1]),
    .prdata(prdata[1]), .pslverr(pslverr[1]), .o_dbg_state(dbg[1]));

  apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(15)) u_dut2 (
    .pclk(pclk), .prst_n(prst_n), .psel(psel[2]), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pready(pready[2]),
    .prdata(prdata[2]), .pslverr(pslverr[2]), .o_dbg_state(dbg[2]));

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge pclk) begin
    if (!prst_n) begin
      prev_rdy <= 3'b000;
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        if (pready[d]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pready: dut%0d got pready=1 expected no response", d);
          end else begin
            check("resp", {29'd0, 2'(d), pslverr[d], prdata[d]},
                  {29'd0, exp_q.pop_front()});
          end
          check("pready_one_cycle", {63'd0, prev_rdy[d]}, 64'd0);
        end
      end
      prev_rdy <= pready;
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the closing edge so the
  // next call starts its setup phase with no idle cycle.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic exp_err,
                      input logic [31:0] exp_rd);
    int  cyc;
    bit  got;
    exp_q.push_back({2'(d), exp_err, exp_rd});
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge pclk);
      cyc++;
      if (pready[d]) got = 1'b1;
    end
    check("latency", 64'(cyc), 64'(WCYC[d] + 1));
    @(posedge pclk); #1;
    psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
  endtask

  task automatic abort_write(input int d, input logic [31:0] addr,
                             input logic [31:0] data, input int n_acc);
    psel[d] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (n_acc) @(posedge pclk);
    #1;
    check("abort_in_wait", {62'd0, dbg[d]}, 64'd1);
    psel = 3'b000; penable = 1'b0;
    @(posedge pclk); #1;
    check("abort_state_idle", {62'd0, dbg[d]}, 64'd0);
    pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
    repeat (20) @(posedge pclk);
    #1;
  endtask

  task automatic check_reset_outputs(input int d);
    check("rst_pready",  {63'd0, pready[d]},  64'd0);
    check("rst_pslverr", {63'd0, pslverr[d]}, 64'd0);
    check("rst_prdata",  {32'd0, prdata[d]},  64'd0);
    check("rst_state",   {62'd0, dbg[d]},     64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    prst_n = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0;
    repeat (3) @(posedge pclk);
    #2;
    for (int d = 0; d < NDUT; d++) check_reset_outputs(d);
    @(negedge pclk); prst_n = 1'b1;
    @(posedge pclk); #1;

    // All registers read zero after reset.
    for (int i = 0; i < 16; i++) xfer(0, 1'b0, 32'(i * 4), 32'd0, 1'b0, 32'd0);

    // Write then back-to-back read-after-write; others stay zero.
    xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0, 32'd0);
    xfer(0, 1'b0, 32'h8, 32'd0,        1'b0, 32'hDEADBEEF);
    for (int i = 0; i < 16; i++)
      xfer(0, 1'b0, 32'(i * 4), 32'd0, 1'b0, (i == 2) ? 32'hDEADBEEF : 32'd0);

    // Error writes: out of range (would alias reg 0) and misaligned (reg 1).
    xfer(0, 1'b1, 32'h0,  32'hA5A50001, 1'b0, 32'd0);
    xfer(0, 1'b1, 32'h40, 32'hBAD00040, 1'b1, 32'd0);
    xfer(0, 1'b1, 32'h6,  32'hBAD00006, 1'b1, 32'd0);
    xfer(0, 1'b0, 32'h0,  32'd0,        1'b0, 32'hA5A50001);
    xfer(0, 1'b0, 32'h4,  32'd0,        1'b0, 32'd0);
    xfer(0, 1'b0, 32'h41, 32'd0,        1'b1, 32'd0);
    xfer(0, 1'b0, 32'h80000000, 32'd0,  1'b1, 32'd0);
    // Last valid register.
    xfer(0, 1'b1, 32'h3C, 32'h0F0F1234, 1'b0, 32'd0);
    xfer(0, 1'b0, 32'h3C, 32'd0,        1'b0, 32'h0F0F1234);

    // Zero wait states.
    xfer(1, 1'b1, 32'h10, 32'h11112222, 1'b0, 32'd0);
    xfer(1, 1'b0, 32'h10, 32'd0,        1'b0, 32'h11112222);
    xfer(1, 1'b0, 32'h44, 32'd0,        1'b1, 32'd0);
    xfer(1, 1'b0, 32'h14, 32'd0,        1'b0, 32'd0);

    // Fifteen wait states.
    xfer(2, 1'b1, 32'h3C, 32'hCAFE0015, 1'b0, 32'd0);
    xfer(2, 1'b0, 32'h3C, 32'd0,        1'b0, 32'hCAFE0015);

    // Abort in WAIT: no write, no response; the next transfer is normal.
    abort_write(2, 32'h20, 32'h5555AAAA, 3);
    xfer(2, 1'b0, 32'h20, 32'd0, 1'b0, 32'd0);
    xfer(2, 1'b0, 32'h3C, 32'd0, 1'b0, 32'hCAFE0015);

    // Reset in the middle of a WAIT-phase write.
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4;
    pwdata = 32'h12345678;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check("pre_rst_wait", {62'd0, dbg[2]}, 64'd1);
    #2;
    prst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) check_reset_outputs(d);
    psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
    repeat (2) @(posedge pclk);
    @(negedge pclk); prst_n = 1'b1;
    @(posedge pclk); #1;
    xfer(2, 1'b0, 32'h4,  32'd0, 1'b0, 32'd0);
    xfer(2, 1'b0, 32'h3C, 32'd0, 1'b0, 32'd0);
    xfer(0, 1'b0, 32'h8,  32'd0, 1'b0, 32'd0);
    xfer(0, 1'b0, 32'h0,  32'd0, 1'b0, 32'd0);

    repeat (3) @(posedge pclk);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
APB completer that terminates transfers from the team's APB master and backs them with a bank of NUM_REGS 32-bit read/write registers. It inserts a fixed, parameterised number of wait states per transfer. It flags misaligned or out-of-range addresses with pslverr. It is the peripheral-side endpoint used in the APB UVM environment and in subsystem integration.

Parameters:
NUM_REGS, 16, number of 32-bit registers; power of two, 2..256
WAIT_CYCLES, 1, pready-low access cycles inserted before completion; 0..15

Ports:
pclk  input  1  APB clock; all state updates on the rising edge
prst_n  input  1  asynchronous active-low reset
psel  input  1  select from master
penable  input  1  access-phase indicator from master
paddr  input  32  byte address
pwrite  input  1  1 = write, 0 = read
pwdata  input  32  write data
pready  output  1  transfer completion
prdata  output  32  read data; valid only while pready=1
pslverr  output  1  error response; valid only while pready=1

Behaviour:
- Async reset (prst_n=0): state=IDLE, all registers=0, pready=0, prdata=0, pslverr=0. Takes effect immediately, independent of pclk. Any in-flight transfer is dropped and no write is committed.
- Address decode:
  - index = paddr[log2(NUM_REGS)+1:2].
  - Error when paddr[1:0]!=0 or paddr >= NUM_REGS*4.
- Capture: paddr, pwrite and pwdata are latched on the setup-phase edge. Decode and commit use only the latched copies.
- FSM states: IDLE, WAIT, RESP. All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - On an edge with psel=1 and penable=0: latch the transfer.
  - If WAIT_CYCLES=0, go to RESP; else go to WAIT with cnt=WAIT_CYCLES.
  - Any other input combination: stay in IDLE.
- WAIT:
  - pready=0.
  - If psel=1 and penable=1: cnt decrements; when cnt reaches 1, go to RESP.
  - If psel=0 or penable=0 (protocol abort): go to IDLE with no write and no response.
- Entering RESP, prdata is loaded as follows:
  - read, no error: prdata = regs[index]
  - error or write: prdata = 0
  - pslverr = error
- RESP:
  - pready=1 for exactly one cycle.
  - At the closing edge: if psel=1, penable=1, pwrite=1 and no error, then regs[index] <= latched pwdata.
  - After the closing edge: pready, pslverr and prdata return to 0 and state returns to IDLE.
  - An error write never modifies any register.
- Latency: access phase lasts WAIT_CYCLES+1 cycles. A full transfer is WAIT_CYCLES+2 cycles including setup.
- Back-to-back transfers: the master may assert setup in the cycle right after RESP. IDLE samples it with no bubble.
- Read-after-write to the same register returns the new value. The write commits before the next setup edge.
- Counter width is 4 bits. cnt never underflows because WAIT_CYCLES=0 bypasses WAIT.

Test Plan:
- Reset then read of every index, WAIT_CYCLES=1 -> prdata=0x0, pslverr=0; pready high in the 2nd access cycle of each transfer.
- Write 0xDEADBEEF to 0x8, then read 0x8 back-to-back -> read returns 0xDEADBEEF; other registers remain 0; no idle cycle required between the two transfers.
- Write to 0x40 (NUM_REGS=16) and write to 0x6 (misaligned) -> pslverr=1 with pready, prdata=0, no register changes; a subsequent read of 0x0 returns its prior value.
- WAIT_CYCLES=0 and WAIT_CYCLES=15 -> pready asserts in access cycle 1 and access cycle 16 respectively, each for exactly one cycle.
- Assert prst_n=0 mid-WAIT during a write of 0x12345678 to 0x4 -> outputs are 0 immediately; after release, a read of 0x4 returns 0.
- Drop psel in WAIT (abort) -> FSM returns to IDLE, no write, pready never asserts; the next normal transfer completes correctly.
